uart_tx_arbiter: RTL and testbench

Shares the single `uart` transmitter among `NUM_REQ` byte-stream requesters (debug console, sensor status, loopback echo, …). Each requester gets round-robin access per byte, or locks the transmitter for a multi-byte message. The block drives the UART's `transmit`/`tx_byte` inputs, sequences each byte against `is_transmitting`, and guards against a transmitter that never starts.

---
 rtl/uart_tx_arbiter_if.sv | 22 ++
 rtl/uart_tx_arbiter.sv | 135 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and UART handshake bundle for uart_tx_arbiter
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
) ();
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 uart_transmit;
    logic [7:0]           uart_tx_byte;
    logic                 uart_is_transmitting;

    modport master (
        output req_valid, req_data, req_last, uart_is_transmitting,
        input  req_ready, uart_transmit, uart_tx_byte
    );

    modport slave (
        input  req_valid, req_data, req_last, uart_is_transmitting,
        output req_ready, uart_transmit, uart_tx_byte
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin/locking arbiter sharing one UART transmitter
module uart_tx_arbiter #(
    parameter int  NUM_REQ       = 4,
    parameter int  START_TIMEOUT = 15,
    localparam int IDW           = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic           clk,
    input  logic           resetn,
    uart_tx_arbiter_if.slave bus,
    output logic [IDW-1:0] grant_id,
    output logic           busy,
    output logic           tx_drop
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_START,
        S_WAIT_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [7:0]     tx_reg_q, tx_reg_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [IDW-1:0] grant_id_q, grant_id_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] lock_id_q, lock_id_d;
    logic           locked_q, locked_d;

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] ready;
    logic [IDW-1:0]     winner;
    logic               found;
    logic [IDW:0]       cand;
    logic               transmit;

    // Round-robin search starting one past the last winner; while locked
    // only the lock holder is a candidate.
    always_comb begin
        eligible = bus.req_valid;
        if (locked_q) begin
            eligible = bus.req_valid & (NUM_REQ'(1) << lock_id_q);
        end
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NUM_REQ)) begin
                cand = cand - (IDW+1)'(NUM_REQ);
            end
            if (!found && eligible[cand[IDW-1:0]]) begin
                found  = 1'b1;
                winner = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        tx_reg_d   = tx_reg_q;
        cnt_d      = cnt_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        lock_id_d  = lock_id_q;
        locked_d   = locked_q;
        ready      = '0;
        transmit   = 1'b0;
        tx_drop    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // resetn gates the Mealy grant so req_ready stays low while reset is held
                if (resetn && found && !bus.uart_is_transmitting) begin
                    ready[winner] = 1'b1;
                    tx_reg_d      = bus.req_data[8*winner +: 8];
                    grant_id_d    = winner;
                    rr_ptr_d      = winner;
                    locked_d      = !bus.req_last[winner];
                    lock_id_d     = winner;
                    state_d       = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                transmit = 1'b1;
                cnt_d    = '0;
                state_d  = S_WAIT_START;
            end
            S_WAIT_START: begin
                if (bus.uart_is_transmitting) begin
                    state_d = S_WAIT_DONE;
                end else if (cnt_q >= 8'(START_TIMEOUT)) begin
                    // Byte is abandoned; the lock set at accept stays as it was.
                    tx_drop = 1'b1;
                    state_d = S_IDLE;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_WAIT_DONE: begin
                if (!bus.uart_is_transmitting) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            tx_reg_q   <= '0;
            cnt_q      <= '0;
            grant_id_q <= '0;
            rr_ptr_q   <= IDW'(NUM_REQ - 1);
            lock_id_q  <= '0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_reg_q   <= tx_reg_d;
            cnt_q      <= cnt_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_id_q  <= lock_id_d;
            locked_q   <= locked_d;
        end
    end

    assign bus.req_ready     = ready;
    assign bus.uart_transmit = transmit;
    assign bus.uart_tx_byte  = tx_reg_q;
    assign grant_id          = grant_id_q;
    assign busy              = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    localparam int NUM_REQ       = 4;
    localparam int START_TIMEOUT = 15;
    localparam int IDW           = 2;
    localparam int U_NORMAL      = 0;
    localparam int U_NEVER       = 1;
    localparam int U_MANUAL      = 2;

    logic           clk = 1'b0;
    logic           resetn;
    logic [IDW-1:0] grant_id;
    logic           busy;
    logic           tx_drop;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ(NUM_REQ),
        .START_TIMEOUT(START_TIMEOUT)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus),
        .grant_id(grant_id),
        .busy(busy),
        .tx_drop(tx_drop)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int uart_mode = U_NORMAL;
    int uart_frame = 40;
    int uart_cnt = 0;
    bit rand_frames = 1'b0;
    logic [7:0] tx_log[$];

    // abstract model state
    bit         m_avail = 1'b1;
    bit         avail_pend = 1'b0;

    typedef struct {
        logic [3:0] valid;
        logic       uart_busy;
        logic [3:0] exp_ready;
    } vec_t;
    vec_t vt[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: bounded wait expired", name);
    endtask

    // One clock cycle plus the UART model: busy rises the cycle after a
    // transmit pulse and stays up for the frame length.
    task automatic tick();
        logic       p_tx;
        logic [7:0] p_byte;
        p_tx   = bus.uart_transmit;
        p_byte = bus.uart_tx_byte;
        @(posedge clk);
        #1;
        cyc++;
        if (avail_pend) begin
            m_avail    = 1'b1;
            avail_pend = 1'b0;
        end
        if (p_tx) tx_log.push_back(p_byte);
        if (uart_mode == U_NORMAL) begin
            if (p_tx) begin
                bus.uart_is_transmitting = 1'b1;
                uart_cnt = rand_frames ? int'($urandom_range(1, 4)) : uart_frame;
            end else if (uart_cnt > 0) begin
                uart_cnt--;
                if (uart_cnt == 0) begin
                    bus.uart_is_transmitting = 1'b0;
                    avail_pend = 1'b1;
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        bus.req_valid = '0;
        bus.req_data = '0;
        bus.req_last = '0;
        bus.uart_is_transmitting = 1'b0;
        uart_mode = U_NORMAL;
        uart_cnt = 0;
        tick();
        tick();
        resetn = 1'b1;
        m_avail = 1'b1;
        avail_pend = 1'b0;
        #1;
    endtask

    task automatic wait_accept(input string name, output int idx);
        idx = -1;
        for (int n = 0; n < 200; n++) begin
            #1;
            if (bus.req_ready != '0) begin
                for (int i = 0; i < NUM_REQ; i++) if (bus.req_ready[i]) idx = i;
                check({name, "_onehot"}, $countones(bus.req_ready), 1);
                tick();
                return;
            end
            tick();
        end
        fail_now({name, "_accept"});
    endtask

    task automatic wait_uart(input string name, input logic level);
        for (int n = 0; n < 100; n++) begin
            if (bus.uart_is_transmitting == level) return;
            tick();
        end
        fail_now(name);
    endtask

    task automatic wait_idle(input string name);
        for (int n = 0; n < 200; n++) begin
            if (!busy) return;
            tick();
        end
        fail_now(name);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int idx;
        int t0;
        int bad;
        bit         pend[NUM_REQ];
        logic [7:0] pd[NUM_REQ];
        bit         pl[NUM_REQ];
        int         m_last, m_lock_id, m_gid, w;
        bit         m_locked, m_tx_next;
        logic [7:0] m_byte;
        logic [3:0] exp_ready;

        vt[0] = '{4'b0000, 1'b0, 4'b0000};
        vt[1] = '{4'b0001, 1'b0, 4'b0001};
        vt[2] = '{4'b1000, 1'b0, 4'b1000};
        vt[3] = '{4'b1010, 1'b0, 4'b0010};
        vt[4] = '{4'b1111, 1'b0, 4'b0001};
        vt[5] = '{4'b0110, 1'b0, 4'b0010};
        vt[6] = '{4'b1100, 1'b0, 4'b0100};
        vt[7] = '{4'b1111, 1'b1, 4'b0000};

        // reset state, with requests pending during reset
        resetn = 1'b0;
        bus.req_valid = 4'b1111;
        bus.req_data = 32'hDEADBEEF;
        bus.req_last = 4'b1111;
        bus.uart_is_transmitting = 1'b0;
        #2;
        check("rst_ready", bus.req_ready, 0);
        check("rst_transmit", bus.uart_transmit, 0);
        check("rst_byte", bus.uart_tx_byte, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_busy", busy, 0);
        check("rst_drop", tx_drop, 0);
        do_reset();

        // grant selection from the reset pointer, one vector per cycle
        for (int v = 0; v < 8; v++) begin
            tick();
            bus.req_valid = vt[v].valid;
            bus.uart_is_transmitting = vt[v].uart_busy;
            #1;
            check($sformatf("vec%0d_ready", v), bus.req_ready, vt[v].exp_ready);
            bus.req_valid = '0;
            bus.uart_is_transmitting = 1'b0;
        end
        tick();

        // single byte
        uart_frame = 40;
        bus.req_data[7:0] = 8'h41;
        bus.req_last = 4'b0001;
        bus.req_valid = 4'b0001;
        #1;
        check("sb_ready", bus.req_ready, 4'b0001);
        tick();
        bus.req_valid = '0;
        check("sb_transmit", bus.uart_transmit, 1);
        check("sb_byte", bus.uart_tx_byte, 8'h41);
        check("sb_grant_id", grant_id, 0);
        check("sb_busy", busy, 1);
        tick();
        check("sb_single_pulse", bus.uart_transmit, 0);
        wait_uart("sb_rise", 1'b1);
        wait_uart("sb_fall", 1'b0);
        check("sb_busy_hold", busy, 1);
        tick();
        check("sb_busy_fall", busy, 0);

        // round robin
        do_reset();
        uart_frame = 3;
        tx_log.delete();
        bus.req_data = 32'hA3A2A1A0;
        bus.req_last = 4'b1111;
        bus.req_valid = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_accept("rr", idx);
            check($sformatf("rr_grant%0d", g), idx, g % 4);
        end
        bus.req_valid = '0;
        wait_idle("rr_idle");
        check("rr_pulses", tx_log.size(), 5);
        for (int g = 0; g < 5 && g < tx_log.size(); g++)
            check($sformatf("rr_byte%0d", g), tx_log[g], 8'hA0 + 8'(g % 4));

        // lock: pointer now sits at 0, so requester 1 wins first
        tx_log.delete();
        bus.req_data = 32'h00201001;
        bus.req_last = 4'b1101;
        bus.req_valid = 4'b0111;
        wait_accept("lk", idx);
        check("lk_grant0", idx, 1);
        bus.req_data[15:8] = 8'h11;
        wait_accept("lk", idx);
        check("lk_grant1", idx, 1);
        bus.req_data[15:8] = 8'h12;
        bus.req_last = 4'b1111;
        wait_accept("lk", idx);
        check("lk_grant2", idx, 1);
        bus.req_valid = 4'b0101;
        wait_accept("lk", idx);
        check("lk_after_unlock", idx, 2);
        bus.req_valid = '0;
        wait_idle("lk_idle");
        check("lk_pulses", tx_log.size(), 4);
        if (tx_log.size() == 4) begin
            check("lk_byte0", tx_log[0], 8'h10);
            check("lk_byte1", tx_log[1], 8'h11);
            check("lk_byte2", tx_log[2], 8'h12);
            check("lk_byte3", tx_log[3], 8'h20);
        end

        // start timeout
        do_reset();
        uart_mode = U_NEVER;
        bus.req_data = 32'h00006655;
        bus.req_last = 4'b1111;
        bus.req_valid = 4'b0011;
        wait_accept("to", idx);
        check("to_first", idx, 0);
        t0 = cyc - 1;
        for (int n = 0; n < 40; n++) begin
            if (tx_drop) break;
            tick();
        end
        check("to_drop_cycle", cyc - t0, 2 + START_TIMEOUT);
        check("to_drop_busy", busy, 1);
        tick();
        check("to_drop_pulse", tx_drop, 0);
        check("to_idle", busy, 0);
        uart_mode = U_NORMAL;
        uart_frame = 3;
        wait_accept("to", idx);
        check("to_next", idx, 1);
        bus.req_valid = '0;
        wait_idle("to_end_idle");

        // UART already busy
        do_reset();
        uart_mode = U_MANUAL;
        bus.uart_is_transmitting = 1'b1;
        bus.req_data = 32'h00770000;
        bus.req_last = 4'b1111;
        bus.req_valid = 4'b0100;
        bad = 0;
        for (int n = 0; n < 5; n++) begin
            #1;
            if (bus.req_ready != '0) bad++;
            tick();
        end
        check("ub_no_ready", bad, 0);
        bus.uart_is_transmitting = 1'b0;
        #1;
        check("ub_ready", bus.req_ready, 4'b0100);
        tick();
        bus.req_valid = '0;
        check("ub_transmit", bus.uart_transmit, 1);
        check("ub_byte", bus.uart_tx_byte, 8'h77);
        tick();
        bus.uart_is_transmitting = 1'b1;
        tick();
        tick();
        bus.uart_is_transmitting = 1'b0;
        tick();
        check("ub_busy_fall", busy, 0);

        // reset in WAIT_DONE while locked to requester 3
        do_reset();
        uart_frame = 40;
        bus.req_data = 32'h3300000A;
        bus.req_last = 4'b0111;
        bus.req_valid = 4'b1000;
        wait_accept("rs", idx);
        check("rs_lock_grant", idx, 3);
        bus.req_valid = 4'b1001;
        wait_uart("rs_rise", 1'b1);
        tick();
        tick();
        check("rs_busy_pre", busy, 1);
        resetn = 1'b0;
        #1;
        check("rs_ready", bus.req_ready, 0);
        check("rs_transmit", bus.uart_transmit, 0);
        check("rs_byte", bus.uart_tx_byte, 0);
        check("rs_grant_id", grant_id, 0);
        check("rs_busy", busy, 0);
        check("rs_drop", tx_drop, 0);
        tick();
        resetn = 1'b1;
        #1;
        check("rs_wait_uart", bus.req_ready, 0);
        wait_accept("rs", idx);
        check("rs_first_after", idx, 0);
        bus.req_valid = '0;
        wait_idle("rs_idle");
        wait_uart("rs_uart_done", 1'b0);
        tick();

        // randomized traffic against a transaction-level model
        do_reset();
        rand_frames = 1'b1;
        m_last = NUM_REQ - 1;
        m_locked = 1'b0;
        m_lock_id = 0;
        m_gid = 0;
        m_tx_next = 1'b0;
        m_byte = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pend[i] = 1'b0;
            pd[i] = '0;
            pl[i] = 1'b1;
        end
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i] = 1'b1;
                    pd[i] = 8'($urandom);
                    pl[i] = ($urandom_range(0, 2) != 0);
                end
                bus.req_valid[i] = pend[i] && ($urandom_range(0, 9) < 7);
                bus.req_data[8*i +: 8] = pd[i];
                bus.req_last[i] = pl[i];
            end
            #1;
            check("rnd_busy", busy, !m_avail);
            check("rnd_transmit", bus.uart_transmit, m_tx_next);
            if (m_tx_next) check("rnd_byte", bus.uart_tx_byte, m_byte);
            check("rnd_grant_id", grant_id, m_gid);
            exp_ready = '0;
            w = -1;
            if (m_avail && !bus.uart_is_transmitting) begin
                for (int k = 1; k <= NUM_REQ; k++) begin
                    int j;
                    j = (m_last + k) % NUM_REQ;
                    if (w < 0 && bus.req_valid[j] && (!m_locked || j == m_lock_id)) w = j;
                end
            end
            if (w >= 0) exp_ready[w] = 1'b1;
            check("rnd_ready", bus.req_ready, exp_ready);
            m_tx_next = 1'b0;
            if (w >= 0) begin
                m_tx_next = 1'b1;
                m_byte = pd[w];
                m_last = w;
                m_gid = w;
                m_locked = !pl[w];
                m_lock_id = w;
                m_avail = 1'b0;
                pend[w] = 1'b0;
            end
            tick();
        end
        bus.req_valid = '0;
        wait_idle("rnd_idle");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
